// File: rtl/next_hop_arb_pkg.sv
// Shared widths and port-id encoding for the next-hop RAM arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package next_hop_pkg;

    localparam int NH_ADDR_W = 11;
    localparam int NH_DATA_W = 32;
    localparam int NH_BE_W   = 4;

    typedef enum logic [1:0] {
        PORT_CFG = 2'd0,
        PORT_LK0 = 2'd1,
        PORT_LK1 = 2'd2
    } port_id_e;

endpackage

// File: rtl/nh_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last-granted port
// and the other port wins a tie.
module nh_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr_q = 1 means port 1 was granted last, so port 0 wins the next tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (advance && (gnt != 2'b00)) begin
            ptr_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/next_hop_arb.sv
// Arbitrates one config port and two lookup ports onto a single external
// next-hop RAM, with a starvation cap and one-cycle read-response routing.
module next_hop_arb
    import next_hop_pkg::*;
#(
    parameter int CFG_MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cfg_req,
    input  logic [NH_BE_W-1:0]   cfg_we,
    input  logic [NH_ADDR_W-1:0] cfg_addr,
    input  logic [NH_DATA_W-1:0] cfg_wdata,
    output logic                 cfg_gnt,
    output logic                 cfg_rvalid,
    output logic [NH_DATA_W-1:0] cfg_rdata,

    input  logic                 lk0_req,
    input  logic [NH_ADDR_W-1:0] lk0_addr,
    output logic                 lk0_gnt,
    output logic                 lk0_rvalid,
    output logic [NH_DATA_W-1:0] lk0_rdata,

    input  logic                 lk1_req,
    input  logic [NH_ADDR_W-1:0] lk1_addr,
    output logic                 lk1_gnt,
    output logic                 lk1_rvalid,
    output logic [NH_DATA_W-1:0] lk1_rdata,

    output logic [NH_ADDR_W-1:0] ram_addr,
    output logic [NH_DATA_W-1:0] ram_din,
    output logic [NH_BE_W-1:0]   ram_we,
    output logic                 ram_en,
    input  logic [NH_DATA_W-1:0] ram_dout
);

    localparam int                 BURST_W   = $clog2(CFG_MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CFG_MAX_BURST);

    logic [BURST_W-1:0] burstCnt_q, burstCnt_d;
    logic               respPend_q, respPend_d;
    port_id_e           respId_q, respId_d;

    logic       lkPending;
    logic       capReached;
    logic       cfgGrant;
    logic       lkGrant;
    logic       cfgRead;
    logic       respValid;
    logic [1:0] rrGnt;

    // Config normally wins; once it has taken CFG_MAX_BURST grants in a row
    // while a lookup waits, the lookup side gets the RAM for one cycle.
    always_comb begin
        lkPending  = lk0_req | lk1_req;
        capReached = (burstCnt_q == BURST_MAX) && lkPending;
        cfgGrant   = !reset && cfg_req && !capReached;
        lkGrant    = !reset && !cfgGrant && lkPending;
        cfgRead    = (cfg_we == '0);
    end

    nh_rr_arb2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({lk1_req, lk0_req}),
        .advance (lkGrant),
        .gnt     (rrGnt)
    );

    always_comb begin
        cfg_gnt = cfgGrant;
        lk0_gnt = lkGrant & rrGnt[0];
        lk1_gnt = lkGrant & rrGnt[1];
    end

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = '0;
        ram_en   = 1'b0;
        if (cfgGrant) begin
            ram_addr = cfg_addr;
            ram_din  = cfg_wdata;
            ram_we   = cfg_we;
            ram_en   = cfgRead;
        end else if (lk0_gnt) begin
            ram_addr = lk0_addr;
            ram_en   = 1'b1;
        end else if (lk1_gnt) begin
            ram_addr = lk1_addr;
            ram_en   = 1'b1;
        end
    end

    always_comb begin
        burstCnt_d = burstCnt_q;
        respPend_d = 1'b0;
        respId_d   = respId_q;
        if (!lkPending || lkGrant) begin
            burstCnt_d = '0;
        end else if (cfgGrant && (burstCnt_q != BURST_MAX)) begin
            burstCnt_d = burstCnt_q + 1'b1;
        end
        if (cfgGrant && cfgRead) begin
            respPend_d = 1'b1;
            respId_d   = PORT_CFG;
        end else if (lk0_gnt) begin
            respPend_d = 1'b1;
            respId_d   = PORT_LK0;
        end else if (lk1_gnt) begin
            respPend_d = 1'b1;
            respId_d   = PORT_LK1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burstCnt_q <= '0;
            respPend_q <= 1'b0;
            respId_q   <= PORT_CFG;
        end else begin
            burstCnt_q <= burstCnt_d;
            respPend_q <= respPend_d;
            respId_q   <= respId_d;
        end
    end

    // A response still in flight when reset rises is dropped, not delivered
    always_comb begin
        respValid  = respPend_q && !reset;
        cfg_rvalid = respValid && (respId_q == PORT_CFG);
        lk0_rvalid = respValid && (respId_q == PORT_LK0);
        lk1_rvalid = respValid && (respId_q == PORT_LK1);
        cfg_rdata  = cfg_rvalid ? ram_dout : '0;
        lk0_rdata  = lk0_rvalid ? ram_dout : '0;
        lk1_rdata  = lk1_rvalid ? ram_dout : '0;
    end

endmodule

// File: tb/tb_next_hop_arb.sv
// Bench for next_hop_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_next_hop_arb;
    import next_hop_pkg::*;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_req;
    logic [3:0]  cfg_we;
    logic [10:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_gnt, cfg_rvalid;
    logic [31:0] cfg_rdata;
    logic        lk0_req, lk1_req;
    logic [10:0] lk0_addr, lk1_addr;
    logic        lk0_gnt, lk1_gnt, lk0_rvalid, lk1_rvalid;
    logic [31:0] lk0_rdata, lk1_rdata;
    logic [10:0] ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_we;
    logic        ram_en;
    logic [31:0] ram_dout;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    next_hop_arb #(.CFG_MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_req    (cfg_req),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_gnt    (cfg_gnt),
        .cfg_rvalid (cfg_rvalid),
        .cfg_rdata  (cfg_rdata),
        .lk0_req    (lk0_req),
        .lk0_addr   (lk0_addr),
        .lk0_gnt    (lk0_gnt),
        .lk0_rvalid (lk0_rvalid),
        .lk0_rdata  (lk0_rdata),
        .lk1_req    (lk1_req),
        .lk1_addr   (lk1_addr),
        .lk1_gnt    (lk1_gnt),
        .lk1_rvalid (lk1_rvalid),
        .lk1_rdata  (lk1_rdata),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_en     (ram_en),
        .ram_dout   (ram_dout)
    );

    // Initial RAM image, shared by the RAM stand-in and the model's shadow copy
    function automatic logic [31:0] initWord(input logic [10:0] a);
        case (a)
            11'h010: return 32'hC0A80001;
            11'h020: return 32'h0A000002;
            11'h7FF: return 32'h11223344;
            default: return 32'(a) * 32'h9E3779B1;
        endcase
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] din,
                                               input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = din[8*b +: 8];
        end
        return r;
    endfunction

    // External RAM stand-in: one-cycle read latency, byte-enabled writes
    logic [31:0] ramMem [2048];
    bit          ramWritten [2048];

    function automatic logic [31:0] ramRead(input logic [10:0] a);
        return ramWritten[a] ? ramMem[a] : initWord(a);
    endfunction

    always @(posedge clk) begin
        if (ram_en) ram_dout <= ramRead(ram_addr);
        if (ram_we != 4'b0000) begin
            ramMem[ram_addr]     <= mergeBytes(ramRead(ram_addr), ram_din, ram_we);
            ramWritten[ram_addr] <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model state: burst length, last lookup winner (1=lk0, 2=lk1),
    // one outstanding response, and a shadow of RAM contents
    int          mBurst    = 0;
    int          mLast     = 2;
    bit          mPendV    = 1'b0;
    int          mPendPort = 0;
    logic [31:0] mPendData = '0;
    logic [31:0] shadowMem [2048];
    bit          shadowSet [2048];

    function automatic logic [31:0] shadowRead(input logic [10:0] a);
        return shadowSet[a] ? shadowMem[a] : initWord(a);
    endfunction

    task automatic modelStep();
        logic [2:0]  eg, ev;
        logic [31:0] er [3];
        logic [10:0] ea;
        logic [31:0] ed;
        logic [3:0]  ew;
        logic        ee;
        bit          lkAny, cfgTurn;
        int          winner;
        eg = '0; ev = '0; ea = '0; ed = '0; ew = '0; ee = 1'b0;
        er[0] = '0; er[1] = '0; er[2] = '0;
        winner = -1;
        if (reset) begin
            mBurst = 0;
            mLast  = 2;
            mPendV = 1'b0;
        end else begin
            if (mPendV) begin
                ev[mPendPort] = 1'b1;
                er[mPendPort] = mPendData;
            end
            lkAny   = lk0_req || lk1_req;
            cfgTurn = cfg_req && !(mBurst == MAXB && lkAny);
            if (cfgTurn)                 winner = 0;
            else if (lk0_req && lk1_req) winner = (mLast == 2) ? 1 : 2;
            else if (lk0_req)            winner = 1;
            else if (lk1_req)            winner = 2;
            mPendV = 1'b0;
            if (winner == 0) begin
                eg[0] = 1'b1;
                ea = cfg_addr; ed = cfg_wdata; ew = cfg_we; ee = (cfg_we == 4'b0000);
                if (cfg_we == 4'b0000) begin
                    mPendV = 1'b1; mPendPort = 0; mPendData = shadowRead(cfg_addr);
                end else begin
                    shadowMem[cfg_addr] = mergeBytes(shadowRead(cfg_addr), cfg_wdata, cfg_we);
                    shadowSet[cfg_addr] = 1'b1;
                end
            end else if (winner > 0) begin
                eg[winner] = 1'b1;
                ea = (winner == 1) ? lk0_addr : lk1_addr;
                ee = 1'b1;
                mPendV = 1'b1; mPendPort = winner; mPendData = shadowRead(ea);
                mLast = winner;
            end
            if (!lkAny || winner > 0) mBurst = 0;
            else if (winner == 0 && mBurst < MAXB) mBurst++;
        end
        checkOutput("grant_rvalid",
                    {lk1_gnt, lk0_gnt, cfg_gnt, lk1_rvalid, lk0_rvalid, cfg_rvalid}, {eg, ev});
        checkOutput("ram_bus", {ram_addr, ram_din, ram_we, ram_en}, {ea, ed, ew, ee});
        checkOutput("rdata", {lk1_rdata, lk0_rdata, cfg_rdata}, {er[2], er[1], er[0]});
    endtask

    initial begin : compareProc
        forever begin
            @(negedge clk);
            modelStep();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit c, input logic [3:0] we, input logic [10:0] ca,
                                 input logic [31:0] wd, input bit l0, input logic [10:0] a0,
                                 input bit l1, input logic [10:0] a1);
        cfg_req = c; cfg_we = we; cfg_addr = ca; cfg_wdata = wd;
        lk0_req = l0; lk0_addr = a0;
        lk1_req = l1; lk1_addr = a1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin : stimProc
        logic [1:0]  tieGnt [4];
        logic [31:0] tieData [4];
        logic [7:0]  capPattern;
        bit          hC, hL0, hL1;
        tieGnt     = '{2'b01, 2'b10, 2'b01, 2'b10};
        tieData    = '{32'hC0A80001, 32'h0A000002, 32'hC0A80001, 32'h0A000002};
        capPattern = 8'b1110_1111;

        // Requests present during reset must not leak through
        reset = 1'b1;
        applyStimulus(1, 4'h0, 11'h005, 32'h0, 1, 11'h010, 1, 11'h020);
        @(negedge clk);
        checkOutput("reset_outputs",
                    {cfg_gnt, lk0_gnt, lk1_gnt, cfg_rvalid, lk0_rvalid, lk1_rvalid, ram_en, ram_we, ram_addr},
                    '0);
        tick();
        doReset();

        $display("[TB] single lookup");
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 1, 11'h010, 0, 11'h0);
        @(negedge clk);
        checkOutput("single_gnt", {lk0_gnt, ram_en, ram_addr}, {1'b1, 1'b1, 11'h010});
        tick();
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        @(negedge clk);
        checkOutput("single_rvalid", {lk0_rvalid, lk1_rvalid}, 2'b10);
        checkOutput("single_rdata", lk0_rdata, 32'hC0A80001);
        tick();

        $display("[TB] lookup tie");
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 4'h0, 11'h0, 32'h0, 1, 11'h010, 1, 11'h020);
            @(negedge clk);
            checkOutput("tie_gnt", {lk1_gnt, lk0_gnt}, tieGnt[i]);
            if (i > 0) checkOutput("tie_rdata", lk0_rdata | lk1_rdata, tieData[i-1]);
            tick();
        end
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        @(negedge clk);
        checkOutput("tie_last_rvalid", {lk1_rvalid, lk0_rvalid}, 2'b10);
        checkOutput("tie_last_rdata", lk1_rdata, 32'h0A000002);
        tick();

        $display("[TB] starvation cap");
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 4'h0, 11'h100, 32'h0, 0, 11'h0, 1, 11'h020);
            @(negedge clk);
            checkOutput("cap_gnt", {cfg_gnt, lk1_gnt}, {capPattern[i], !capPattern[i]});
            tick();
        end

        $display("[TB] byte write");
        applyStimulus(1, 4'b0010, 11'h7FF, 32'h0000AB00, 0, 11'h0, 0, 11'h0);
        @(negedge clk);
        checkOutput("bw_write", {cfg_gnt, ram_en, ram_we, ram_din}, {1'b1, 1'b0, 4'b0010, 32'h0000AB00});
        tick();
        applyStimulus(1, 4'b0000, 11'h7FF, 32'h0, 0, 11'h0, 0, 11'h0);
        @(negedge clk);
        checkOutput("bw_no_rvalid", {cfg_gnt, cfg_rvalid, ram_en}, 3'b101);
        tick();
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        @(negedge clk);
        checkOutput("bw_read", {cfg_rvalid, cfg_rdata}, {1'b1, 32'h1122AB44});
        tick();

        $display("[TB] reset mid-read");
        doReset();
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 1, 11'h010, 0, 11'h0);
        @(negedge clk);
        checkOutput("mid_gnt", lk0_gnt, 1'b1);
        tick();
        reset = 1'b1;
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        @(negedge clk);
        checkOutput("mid_zero",
                    {lk0_rvalid, lk0_rdata, cfg_rvalid, lk1_rvalid, ram_en, ram_we, ram_addr, ram_din},
                    '0);
        tick();
        reset = 1'b0;
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 1, 11'h010, 1, 11'h020);
        @(negedge clk);
        checkOutput("mid_tie", {lk1_gnt, lk0_gnt}, 2'b01);
        tick();

        $display("[TB] random traffic");
        hC = 1'b0; hL0 = 1'b0; hL1 = 1'b0;
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!hC) begin
                cfg_req = ($urandom_range(0, 99) < 40);
                cfg_we  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                cfg_addr  = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
                cfg_wdata = $urandom;
            end
            if (!hL0) begin
                lk0_req  = ($urandom_range(0, 99) < 35);
                lk0_addr = 11'($urandom_range(0, 15));
            end
            if (!hL1) begin
                lk1_req  = ($urandom_range(0, 99) < 35);
                lk1_addr = 11'($urandom_range(0, 15));
            end
            @(negedge clk);
            hC  = cfg_req && !cfg_gnt;
            hL0 = lk0_req && !lk0_gnt;
            hL1 = lk1_req && !lk1_gnt;
            tick();
        end
        reset = 1'b0;
        applyStimulus(0, 4'h0, 11'h0, 32'h0, 0, 11'h0, 0, 11'h0);
        tick();
        tick();

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/next_hop_arb.md
NEXT_HOP_ARB -- requirements
Module: next_hop_arb

Interface
REQ-001 Parameter CFG_MAX_BURST, default 4, max consecutive config grants while any lookup request is pending.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cfg_req  input  1  config port request; held until cfg_gnt.
REQ-005 cfg_we  input  4  config byte write enables; 4'b0000 = read.
REQ-006 cfg_addr  input  11 ([12:2])  config word address.
REQ-007 cfg_wdata  input  32  config write data.
REQ-008 cfg_gnt  output  1  config request accepted this cycle.
REQ-009 cfg_rvalid  output  1  config read data valid.
REQ-010 cfg_rdata  output  32  config read data.
REQ-011 lk0_req / lk1_req  input  1 each  lookup read request; held until grant.
REQ-012 lk0_addr / lk1_addr  input  11 each ([12:2])  lookup word address.
REQ-013 lk0_gnt / lk1_gnt  output  1 each  lookup request accepted this cycle.
REQ-014 lk0_rvalid / lk1_rvalid  output  1 each  lookup read data valid.
REQ-015 lk0_rdata / lk1_rdata  output  32 each  lookup read data.
REQ-016 ram_addr  output  11 ([12:2])  to next-hop RAM address.
REQ-017 ram_din  output  32  to next-hop RAM write data.
REQ-018 ram_we  output  4  to next-hop RAM byte write enables.
REQ-019 ram_en  output  1  to next-hop RAM read enable.
REQ-020 ram_dout  input  32  from next-hop RAM; valid one cycle after ram_en.

Function
REQ-021 At most one grant asserted per cycle; grant is combinational from the current-cycle requests and registered state.
REQ-022 Granted request drives ram_addr/ram_we/ram_din/ram_en in the same cycle; with no grant, ram_en=0, ram_we=0, ram_addr/ram_din=0.
REQ-023 Config read: ram_en=1, ram_we=0; config write: ram_en=0, ram_we=cfg_we, no rvalid generated.
REQ-024 Lookup grant: ram_en=1, ram_we=0, ram_din=0.
REQ-025 Priority: config over lookups, except when burst counter equals CFG_MAX_BURST and any lookup request is pending, in which case a lookup is granted.
REQ-026 Burst counter: increments on a config grant while a lookup is pending; clears on any lookup grant or any cycle with no lookup pending; saturates at CFG_MAX_BURST.
REQ-027 Lookup-vs-lookup: round-robin; pointer names the last-granted lookup port, the other port wins a tie; pointer updates only on a lookup grant.
REQ-028 Read latency: grant in cycle N -> matching *_rvalid=1 in cycle N+1 with *_rdata = ram_dout; exactly one rvalid per read grant.
REQ-029 Response tracking: a registered pending flag plus 2-bit port id captured on every read grant; a new grant in N+1 is allowed (full throughput, one read per cycle).
REQ-030 *_rdata are zero whenever the corresponding *_rvalid is 0.
REQ-031 Write in N followed by read of same address in N+1 returns the written bytes (RAM ordering preserved; no reordering or buffering).
REQ-032 Address, data and we of the granted port pass through unmodified; no width conversion.

Reset
REQ-033 While reset=1: all gnt, rvalid, ram_en, ram_we = 0; all rdata, ram_addr, ram_din = 0.
REQ-034 Reset clears burst counter, pending flag, port id; round-robin pointer resets to lk1 (so lk0 wins first tie).
REQ-035 A read granted in the cycle before reset asserts produces no rvalid.

Structure
REQ-036 Shared package next_hop_pkg holds NH_ADDR_W=11, NH_DATA_W=32, NH_BE_W=4 and the port-id encoding (CFG=0, LK0=1, LK1=2).
REQ-037 Two-way round-robin lookup arbiter implemented as sub-module nh_rr_arb2 (req[1:0], advance, gnt[1:0], pointer state).
REQ-038 RAM is external; this block contains no storage other than arbitration and response-tracking state.

Verification
REQ-039 Single lookup: lk0_req, addr 0x010, RAM holds 0xC0A80001 -> lk0_gnt cycle N, lk0_rvalid cycle N+1, lk0_rdata=0xC0A80001.
REQ-040 Tie: lk0_req and lk1_req held 4 cycles after reset -> grants lk0, lk1, lk0, lk1; rvalids follow one cycle later with matching data.
REQ-041 Starvation cap: cfg_req held 8 cycles with lk1_req held, CFG_MAX_BURST=4 -> cfg_gnt cycles 0-3, lk1_gnt cycle 4, cfg_gnt cycles 5-7.
REQ-042 Byte write: cfg write addr 0x7FF, we=4'b0010, wdata=0x0000AB00 over 0x11223344, then cfg read -> cfg_rdata=0x1122AB44, no rvalid on write.
REQ-043 Reset mid-read: lk0 granted cycle N, reset=1 in N+1 -> lk0_rvalid=0, all outputs zero, next tie grants lk0.
